// File: rtl/tennis_pkg.sv
// tennis_pkg: shared FSM state encoding, player encoding and default parameters for the tennis point controller
package tennis_pkg;
  typedef enum logic [2:0] {
    S_SERVE    = 3'd0,
    S_RALLY    = 3'd1,
    S_POINT    = 3'd2,
    S_GAMEOVER = 3'd3
  } state_t;
  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;
  localparam int DEF_NUM_POS    = 16;
  localparam int DEF_WIN_SCORE  = 7;
  localparam int DEF_HIT_WIN    = 2;
  localparam int DEF_HOLD_TICKS = 8;
endpackage

// File: rtl/tennis_step_gen.sv
// tennis_step_gen: turns tick into the ball step strobe, optionally prescaled (macro TENNIS_SPEEDUP_EN)
// Ports: clk/reset (sync, active-high); tick: step strobe in; active: rally in progress;
//        ret: successful return this cycle; step: ball should advance this cycle.
// With TENNIS_SPEEDUP_EN the period starts at 4 ticks per serve and shrinks by one per return down to 1.
module tennis_step_gen (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic active,
  input  logic ret,
  output logic step
);
`ifdef TENNIS_SPEEDUP_EN
  logic [2:0] n, cnt;
  // >= rather than == so a period shrink below the running count fires on the next tick
  assign step = tick && active && (cnt >= n - 3'd1);
  always_ff @(posedge clk) begin
    if (reset || !active) begin
      n   <= 3'd4;
      cnt <= 3'd0;
    end else begin
      if (tick) cnt <= step ? 3'd0 : cnt + 3'd1;
      if (ret && n > 3'd1) n <= n - 3'd1;
    end
  end
`else
  logic unused_sig;
  assign unused_sig = ^{clk, reset, active, ret};
  assign step = tick;
`endif
endmodule

// File: rtl/tennis_point_ctrl.sv
// tennis_point_ctrl: two-player LED tennis point controller (serve, rally, scoring, game over)
// Ports: clk, reset (sync, active-high); tick: step strobe; p1_hit/p2_hit: press pulses;
//        ball_pos/ball_dir: ball index and direction (1 = toward P2); p1_score/p2_score;
//        server (0 = P1); state: encoded FSM state; point_pulse: one cycle per point;
//        game_over/winner. Optional macro TENNIS_SPEEDUP_EN enables the rally speed-up in tennis_step_gen.
module tennis_point_ctrl
  import tennis_pkg::*;
#(
  parameter int NUM_POS    = DEF_NUM_POS,
  parameter int WIN_SCORE  = DEF_WIN_SCORE,
  parameter int HIT_WIN    = DEF_HIT_WIN,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic [3:0] ball_pos,
  output logic       ball_dir,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       server,
  output logic [2:0] state,
  output logic       point_pulse,
  output logic       game_over,
  output logic       winner
);
  localparam logic [3:0] LAST = 4'(NUM_POS - 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  state_t st;
  logic [HW-1:0] hold_cnt;
  logic step, rally, rx_hit, in_win, at_end, ret, early, miss, nd, pt_win;
  logic [3:0] new_score;
  assign state = st;
  assign rally = st == S_RALLY;
  // ball_dir names the receiving player directly (0 = P1, 1 = P2)
  assign rx_hit = ball_dir ? p2_hit : p1_hit;
  assign in_win = ball_dir ? (ball_pos >= 4'(NUM_POS - HIT_WIN)) : (ball_pos < 4'(HIT_WIN));
  assign at_end = ball_pos == (ball_dir ? LAST : 4'd0);
  assign ret = rx_hit && in_win;
  assign early = rx_hit && !in_win;
  assign miss = step && at_end && !rx_hit;
  // a coincident tick steps in the post-hit direction
  assign nd = ret ? ~ball_dir : ball_dir;
  assign pt_win = ~ball_dir;
  assign new_score = (pt_win ? p2_score : p1_score) + 4'd1;
  tennis_step_gen u_step (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .active (rally),
    .ret    (rally && ret),
    .step   (step)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= S_SERVE;
      server      <= P1;
      ball_pos    <= 4'd0;
      ball_dir    <= 1'b1;
      p1_score    <= 4'd0;
      p2_score    <= 4'd0;
      point_pulse <= 1'b0;
      game_over   <= 1'b0;
      winner      <= P1;
      hold_cnt    <= '0;
    end else begin
      point_pulse <= 1'b0;
      case (st)
        S_SERVE: if (server ? p2_hit : p1_hit) st <= S_RALLY;
        S_RALLY:
          if (early || miss) begin
            if (pt_win) p2_score <= new_score;
            else p1_score <= new_score;
            point_pulse <= 1'b1;
            hold_cnt    <= '0;
            if (new_score == 4'(WIN_SCORE)) begin
              st        <= S_GAMEOVER;
              game_over <= 1'b1;
              winner    <= pt_win;
            end else st <= S_POINT;
          end else begin
            ball_dir <= nd;
            if (step) ball_pos <= nd ? ball_pos + 4'd1 : ball_pos - 4'd1;
          end
        S_POINT:
          if (tick) begin
            if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
              st       <= S_SERVE;
              server   <= ~server;
              ball_pos <= server ? 4'd0 : LAST;
              ball_dir <= server;
              hold_cnt <= '0;
            end else hold_cnt <= hold_cnt + 1'b1;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tennis_point_ctrl.sv
// tb_tennis_point_ctrl: directed scoreboard bench for tennis_point_ctrl (default build)
module tb_tennis_point_ctrl;
  typedef struct packed {
    logic [2:0] st;
    logic [3:0] pos;
    logic       dir;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       srv;
    logic       pulse;
    logic       go;
    logic       win;
  } exp_t;
  logic clk = 0, reset = 1, tick = 0, p1_hit = 0, p2_hit = 0;
  logic [3:0] ball_pos, p1_score, p2_score;
  logic ball_dir, server, point_pulse, game_over, winner;
  logic [2:0] state;
  exp_t q[$];
  string nq[$];
  int vectors = 0, miscompares = 0;
  tennis_point_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .p1_hit(p1_hit), .p2_hit(p2_hit),
    .ball_pos(ball_pos), .ball_dir(ball_dir), .p1_score(p1_score), .p2_score(p2_score),
    .server(server), .state(state), .point_pulse(point_pulse), .game_over(game_over),
    .winner(winner)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e, a;
      string n;
      e = q.pop_front();
      n = nq.pop_front();
      a = '{state, ball_pos, ball_dir, p1_score, p2_score, server, point_pulse, game_over, winner};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got st=%0d pos=%0d dir=%0d s1=%0d s2=%0d srv=%0d pulse=%0d go=%0d win=%0d, expected st=%0d pos=%0d dir=%0d s1=%0d s2=%0d srv=%0d pulse=%0d go=%0d win=%0d",
                 n, a.st, a.pos, a.dir, a.s1, a.s2, a.srv, a.pulse, a.go, a.win,
                 e.st, e.pos, e.dir, e.s1, e.s2, e.srv, e.pulse, e.go, e.win);
      end
    end
  end
  task automatic chk(input string n, input logic [2:0] s, input logic [3:0] p, input logic d,
                     input logic [3:0] a, input logic [3:0] b, input logic sv, input logic pu,
                     input logic g, input logic w);
    q.push_back('{s, p, d, a, b, sv, pu, g, w});
    nq.push_back(n);
  endtask
  task automatic cyc(input logic t, input logic a, input logic b);
    @(negedge clk);
    tick = t; p1_hit = a; p2_hit = b;
    @(posedge clk);
    #1;
    tick = 0; p1_hit = 0; p2_hit = 0;
  endtask
  task automatic ticks(input int n);
    repeat (n) cyc(1, 0, 0);
  endtask
  task automatic do_reset(input logic t, input logic a, input logic b);
    @(negedge clk);
    reset = 1; tick = t; p1_hit = a; p2_hit = b;
    @(posedge clk);
    #1;
    reset = 0; tick = 0; p1_hit = 0; p2_hit = 0;
  endtask
  initial begin
    do_reset(0, 0, 0);
    chk("reset", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1);
    chk("serve_ignores", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0);
    chk("p1_serve", 1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0);
    chk("first_tick", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0);
    chk("sender_hit_ignored", 1, 2, 1, 0, 0, 0, 0, 0, 0);
    ticks(13);
    chk("reach_pos15", 1, 15, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1);
    chk("return_at_15", 1, 15, 0, 0, 0, 0, 0, 0, 0);
    ticks(14);
    chk("reach_pos1", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0);
    chk("hit_with_tick", 1, 2, 1, 0, 0, 0, 0, 0, 0);
    ticks(8);
    chk("reach_pos10", 1, 10, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1);
    chk("early_swing", 2, 10, 1, 1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0);
    chk("pulse_one_cycle", 2, 10, 1, 1, 0, 0, 0, 0, 0);
    ticks(7);
    chk("hold_7", 2, 10, 1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0);
    chk("serve_p2", 0, 15, 0, 1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0);
    chk("receiver_serve_ignored", 0, 15, 0, 1, 0, 1, 0, 0, 0);
    cyc(0, 0, 1);
    chk("p2_serve", 1, 15, 0, 1, 0, 1, 0, 0, 0);
    ticks(15);
    chk("reach_pos0", 1, 0, 0, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0);
    chk("miss_at_0", 2, 0, 0, 1, 1, 1, 1, 0, 0);
    ticks(8);
    chk("serve_p1_again", 0, 0, 1, 1, 1, 0, 0, 0, 0);
    for (int k = 2; k <= 7; k++) begin
      logic srv;
      logic [3:0] pos;
      srv = (k % 2) != 0;
      if (!srv) begin
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        pos = 4'd0;
      end else begin
        cyc(0, 0, 1);
        ticks(14);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        pos = 4'd1;
      end
      if (k < 7) begin
        chk("p1_point", 2, pos, 1, 4'(k), 1, srv, 1, 0, 0);
        ticks(8);
        chk("next_serve", 0, srv ? 4'd0 : 4'd15, srv, 4'(k), 1, ~srv, 0, 0, 0);
      end else chk("game_over", 3, pos, 1, 7, 1, 1, 1, 1, 0);
    end
    cyc(1, 1, 1);
    cyc(1, 0, 1);
    cyc(0, 1, 0);
    chk("gameover_hold", 3, 1, 1, 7, 1, 1, 0, 1, 0);
    do_reset(1, 1, 1);
    chk("reset_from_gameover", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0);
    ticks(5);
    chk("rally_pos5", 1, 5, 1, 0, 0, 0, 0, 0, 0);
    do_reset(1, 1, 0);
    chk("reset_mid_rally", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
